// File: rtl/auth_resp_serializer_if.sv
// auth_resp_serializer_if: request capture and byte-stream bus for the auth response serializer
// Signals:
//   Ack_in, Error_Invalid_Request, header_in, payload_in, wLength -- parallel response from the answer generator
//   tx_ready -- sink accepts tx_data this cycle
//   tx_data, tx_valid, tx_last -- byte stream toward the transport
//   busy, Error_Length -- status
// Modports: master drives requests and tx_ready; slave is the serializer.
interface auth_resp_serializer_if #(parameter int PAYLOAD_BYTES = 256);
  logic                       Ack_in;
  logic                       Error_Invalid_Request;
  logic [31:0]                header_in;
  logic [8*PAYLOAD_BYTES-1:0] payload_in;
  logic [15:0]                wLength;
  logic                       tx_ready;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_last;
  logic                       busy;
  logic                       Error_Length;
  modport master(output Ack_in, Error_Invalid_Request, header_in, payload_in, wLength, tx_ready,
                 input tx_data, tx_valid, tx_last, busy, Error_Length);
  modport slave(input Ack_in, Error_Invalid_Request, header_in, payload_in, wLength, tx_ready,
                output tx_data, tx_valid, tx_last, busy, Error_Length);
endinterface

// File: rtl/auth_resp_serializer.sv
// auth_resp_serializer: captures one parallel auth response and streams it as bytes (header then payload)
// Ports: clk, reset (async, active-high), bus (auth_resp_serializer_if.slave: request inputs,
//   tx_data/tx_valid/tx_last/tx_ready stream, busy, Error_Length pulse).
// Option: define AUTH_TX_CHECKSUM_EN to append an XOR checksum byte after the message.
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif
module auth_resp_serializer #(
  parameter int         PAYLOAD_BYTES       = 256,
  parameter logic [7:0] ERROR_CMD           = 8'h7F,
  parameter logic [7:0] ERR_INVALID_REQUEST = 8'h01,
  parameter logic [7:0] ERR_UNSPECIFIED     = 8'h04
) (
  input logic clk,
  input logic reset,
  auth_resp_serializer_if.slave bus
);
  localparam logic [15:0] PB = 16'(PAYLOAD_BYTES);
  typedef enum logic [2:0] {IDLE, HDR, PLD, DONE `ifdef AUTH_TX_CHECKSUM_EN , CSUM `endif} state_t;
  state_t state, state_n, tail;
  logic [31:0] hdr;
  logic [8*PAYLOAD_BYTES-1:0] pld;
  logic [1:0] cnt;
  logic [15:0] len;
  logic err_len, capture, ovf, xfer;
`ifdef AUTH_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign tail = CSUM;
  assign bus.tx_valid = state == HDR || state == PLD || state == CSUM;
  assign bus.tx_data = state == HDR ? hdr[31:24] : state == PLD ? pld[8*PAYLOAD_BYTES-1 -: 8] : csum;
  assign bus.tx_last = state == CSUM;
`else
  assign tail = DONE;
  assign bus.tx_valid = state == HDR || state == PLD;
  assign bus.tx_data = state == HDR ? hdr[31:24] : state == PLD ? pld[8*PAYLOAD_BYTES-1 -: 8] : 8'h00;
  assign bus.tx_last = (state == HDR && cnt == 2'd3 && len == 16'd0) || (state == PLD && len == 16'd1);
`endif
  assign capture = state == IDLE && bus.Ack_in;
  assign ovf = !bus.Error_Invalid_Request && bus.wLength > PB;
  assign xfer = bus.tx_valid && bus.tx_ready;
  assign bus.busy = state != IDLE;
  assign bus.Error_Length = err_len;
  // DONE waits for Ack_in to fall so a held acknowledge never retransmits
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.Ack_in ? HDR : IDLE)
            : state == HDR  ? (xfer && cnt == 2'd3 ? (len != 16'd0 ? PLD : tail) : HDR)
            : state == PLD  ? (xfer && len == 16'd1 ? tail : PLD)
            : state == DONE ? (bus.Ack_in ? DONE : IDLE)
            : (xfer ? DONE : state);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hdr     <= '0;
      pld     <= '0;
      cnt     <= '0;
      len     <= '0;
      err_len <= 1'b0;
`ifdef AUTH_TX_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      state   <= state_n;
      err_len <= capture && ovf;
      if (capture) begin
        cnt <= '0;
        hdr <= bus.Error_Invalid_Request ? {`PROTOCOL_VERSION, ERROR_CMD, ERR_INVALID_REQUEST, 8'h00}
             : ovf ? {`PROTOCOL_VERSION, ERROR_CMD, ERR_UNSPECIFIED, 8'h00} : bus.header_in;
        len <= bus.Error_Invalid_Request || ovf ? 16'd0 : bus.wLength;
        // left-align the payload so byte 0 is always the top byte; unused when length is forced to 0
        pld <= bus.payload_in << {PB - bus.wLength, 3'b000};
`ifdef AUTH_TX_CHECKSUM_EN
        csum <= '0;
`endif
      end else if (xfer) begin
`ifdef AUTH_TX_CHECKSUM_EN
        csum <= csum ^ bus.tx_data;
`endif
        if (state == HDR) begin
          hdr <= {hdr[23:0], 8'h00};
          cnt <= cnt + 2'd1;
        end
        if (state == PLD) begin
          pld <= pld << 8;
          len <= len - 16'd1;
        end
      end
    end
  end
endmodule
